// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Hard-wired sequencer for a simple accumulator machine. A six-state one-hot
// ring counter (T1..T6) walks every instruction through a common three-state
// fetch (T1-T3) and an opcode-specific execute (T4-T6). All datapath control
// strobes are decoded combinationally from the current T-state and cu_op.
//
// Optional feature: define CU_JC_EN to enable JC (0111, jump if carry).
// Without it 0111 is a NOP; the carry flag and its ADD/SUB capture stay.
//
// Ports
//   cu_clk       in   system clock, rising-edge active
//   cu_rst       in   asynchronous active-high reset
//   cu_op[3:0]   in   opcode (IR upper nibble), valid during T4-T6
//   cu_cy        in   ALU carry-out (bit 8 of the 9-bit result)
//   cu_pc_out    out  PC drives bus
//   cu_pc_inc    out  PC increment
//   cu_pc_load   out  PC loads from bus
//   cu_mar_load  out  MAR loads from bus
//   cu_ram_out   out  RAM drives bus
//   cu_ir_load   out  IR loads from bus
//   cu_ir_out    out  IR operand field drives bus
//   cu_a_load    out  A loads from bus
//   cu_a_out     out  A drives bus
//   cu_b_load    out  B loads from bus
//   cu_o_load    out  output register loads from bus
//   cu_alu_out   out  ALU drives bus
//   cu_alu_cut   out  ALU mode: 1 subtract, 0 add
//   cu_halt      out  processor halted
//   cu_cf        out  registered carry flag
//   cu_tstate    out  one-hot T-state, bit0=T1 .. bit5=T6
// -----------------------------------------------------------------------------
module control_unit (
    input  logic       cu_clk,
    input  logic       cu_rst,
    input  logic [3:0] cu_op,
    input  logic       cu_cy,
    output logic       cu_pc_out,
    output logic       cu_pc_inc,
    output logic       cu_pc_load,
    output logic       cu_mar_load,
    output logic       cu_ram_out,
    output logic       cu_ir_load,
    output logic       cu_ir_out,
    output logic       cu_a_load,
    output logic       cu_a_out,
    output logic       cu_b_load,
    output logic       cu_o_load,
    output logic       cu_alu_out,
    output logic       cu_alu_cut,
    output logic       cu_halt,
    output logic       cu_cf,
    output logic [5:0] cu_tstate
);

    // -------------------------------------------------------------------------
    // T-state encodings (one-hot ring)
    // -------------------------------------------------------------------------
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // -------------------------------------------------------------------------
    // Opcodes
    // -------------------------------------------------------------------------
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

`ifdef CU_JC_EN
    localparam logic JC_EN = 1'b1;
`else
    localparam logic JC_EN = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [5:0] r_tstate;
    logic       r_halt;
    logic       r_cf;

    // -------------------------------------------------------------------------
    // Internal nets
    // -------------------------------------------------------------------------
    logic [5:0] w_tstate_next;
    logic       w_hlt_entry;
    logic       w_halt_active;
    logic       w_is_arith;
    logic       w_cf_capture;
    logic       w_ctl_en;

    // Raw (ungated) decode of the control word
    logic w_pc_out;
    logic w_pc_inc;
    logic w_pc_load;
    logic w_mar_load;
    logic w_ram_out;
    logic w_ir_load;
    logic w_ir_out;
    logic w_a_load;
    logic w_a_out;
    logic w_b_load;
    logic w_o_load;
    logic w_alu_out;
    logic w_alu_cut;

    // -------------------------------------------------------------------------
    // Halt detection
    // -------------------------------------------------------------------------
    // Halt must be visible in the very T4 cycle that decodes HLT, so the
    // registered flag is ORed with the live decode. Once latched, the flag
    // keeps the machine halted regardless of what cu_op does afterwards.
    assign w_hlt_entry   = (r_tstate == T4) && (cu_op == OP_HLT);
    assign w_halt_active = r_halt | w_hlt_entry;

    // Carry is captured only on the edge that closes T6 of ADD/SUB.
    assign w_is_arith   = (cu_op == OP_ADD) || (cu_op == OP_SUB);
    assign w_cf_capture = (r_tstate == T6) && w_is_arith && !w_halt_active;

    // Reset and halt both silence every strobe; reset also dominates halt.
    assign w_ctl_en = !cu_rst && !w_halt_active;

    // -------------------------------------------------------------------------
    // Ring counter next-state
    // -------------------------------------------------------------------------
    always_comb begin
        w_tstate_next = T1;
        case (r_tstate)
            T1:      w_tstate_next = T2;
            T2:      w_tstate_next = T3;
            T3:      w_tstate_next = T4;
            T4:      w_tstate_next = T5;
            T5:      w_tstate_next = T6;
            T6:      w_tstate_next = T1;
            // Any non-one-hot value (e.g. after an upset) restarts fetch.
            default: w_tstate_next = T1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge cu_clk or posedge cu_rst) begin
        if (cu_rst) begin
            r_tstate <= T1;
        end else if (!w_halt_active) begin
            r_tstate <= w_tstate_next;
        end
    end

    always_ff @(posedge cu_clk or posedge cu_rst) begin
        if (cu_rst) begin
            r_halt <= 1'b0;
        end else if (w_hlt_entry) begin
            r_halt <= 1'b1;
        end
    end

    always_ff @(posedge cu_clk or posedge cu_rst) begin
        if (cu_rst) begin
            r_cf <= 1'b0;
        end else if (w_cf_capture) begin
            r_cf <= cu_cy;
        end
    end

    // -------------------------------------------------------------------------
    // Control word decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_pc_out   = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_load  = 1'b0;
        w_mar_load = 1'b0;
        w_ram_out  = 1'b0;
        w_ir_load  = 1'b0;
        w_ir_out   = 1'b0;
        w_a_load   = 1'b0;
        w_a_out    = 1'b0;
        w_b_load   = 1'b0;
        w_o_load   = 1'b0;
        w_alu_out  = 1'b0;
        w_alu_cut  = 1'b0;

        case (r_tstate)
            // ---------------- fetch: common to every opcode ----------------
            T1: begin
                w_pc_out   = 1'b1;
                w_mar_load = 1'b1;
            end
            T2: begin
                w_pc_inc = 1'b1;
            end
            T3: begin
                w_ram_out = 1'b1;
                w_ir_load = 1'b1;
            end

            // ---------------- execute ----------------
            T4: begin
                case (cu_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        w_ir_out   = 1'b1;
                        w_mar_load = 1'b1;
                    end
                    OP_JMP: begin
                        w_ir_out  = 1'b1;
                        w_pc_load = 1'b1;
                    end
                    OP_JC: begin
                        if (JC_EN && r_cf) begin
                            w_ir_out  = 1'b1;
                            w_pc_load = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        w_a_out  = 1'b1;
                        w_o_load = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            T5: begin
                case (cu_op)
                    OP_LDA: begin
                        w_ram_out = 1'b1;
                        w_a_load  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_ram_out = 1'b1;
                        w_b_load  = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            T6: begin
                if (w_is_arith) begin
                    w_alu_out = 1'b1;
                    w_a_load  = 1'b1;
                    // Subtract mode only while the ALU actually owns the bus.
                    w_alu_cut = (cu_op == OP_SUB);
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cu_pc_out   = w_pc_out   & w_ctl_en;
    assign cu_pc_inc   = w_pc_inc   & w_ctl_en;
    assign cu_pc_load  = w_pc_load  & w_ctl_en;
    assign cu_mar_load = w_mar_load & w_ctl_en;
    assign cu_ram_out  = w_ram_out  & w_ctl_en;
    assign cu_ir_load  = w_ir_load  & w_ctl_en;
    assign cu_ir_out   = w_ir_out   & w_ctl_en;
    assign cu_a_load   = w_a_load   & w_ctl_en;
    assign cu_a_out    = w_a_out    & w_ctl_en;
    assign cu_b_load   = w_b_load   & w_ctl_en;
    assign cu_o_load   = w_o_load   & w_ctl_en;
    assign cu_alu_out  = w_alu_out  & w_ctl_en;
    assign cu_alu_cut  = w_alu_cut  & w_ctl_en;

    assign cu_halt   = w_halt_active & !cu_rst;
    assign cu_cf     = r_cf;
    assign cu_tstate = r_tstate;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Scoreboard bench: a driver applies inputs just after each rising edge,
// advances a step-counter reference model and pushes the expected output
// word; a monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic       cu_clk;
    logic       cu_rst;
    logic [3:0] cu_op;
    logic       cu_cy;
    logic       cu_pc_out, cu_pc_inc, cu_pc_load, cu_mar_load, cu_ram_out;
    logic       cu_ir_load, cu_ir_out, cu_a_load, cu_a_out, cu_b_load;
    logic       cu_o_load, cu_alu_out, cu_alu_cut, cu_halt, cu_cf;
    logic [5:0] cu_tstate;

    control_unit dut (
        .cu_clk      (cu_clk),
        .cu_rst      (cu_rst),
        .cu_op       (cu_op),
        .cu_cy       (cu_cy),
        .cu_pc_out   (cu_pc_out),
        .cu_pc_inc   (cu_pc_inc),
        .cu_pc_load  (cu_pc_load),
        .cu_mar_load (cu_mar_load),
        .cu_ram_out  (cu_ram_out),
        .cu_ir_load  (cu_ir_load),
        .cu_ir_out   (cu_ir_out),
        .cu_a_load   (cu_a_load),
        .cu_a_out    (cu_a_out),
        .cu_b_load   (cu_b_load),
        .cu_o_load   (cu_o_load),
        .cu_alu_out  (cu_alu_out),
        .cu_alu_cut  (cu_alu_cut),
        .cu_halt     (cu_halt),
        .cu_cf       (cu_cf),
        .cu_tstate   (cu_tstate)
    );

    initial cu_clk = 1'b0;
    always #5 cu_clk = ~cu_clk;

`ifdef CU_JC_EN
    localparam bit JC_ON = 1'b1;
`else
    localparam bit JC_ON = 1'b0;
`endif

    typedef struct packed {
        logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
        logic       a_load, a_out, b_load, o_load, alu_out, alu_cut, halt, cf;
        logic [5:0] ts;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: instruction step 1..6, latched halt, carry flag,
    // plus the inputs in force during the current cycle.
    int unsigned m_step   = 1;
    bit          m_halted = 0;
    logic        m_cf     = 1'b0;
    logic        m_rst    = 1'b1;
    logic [3:0]  m_op     = 4'h0;
    logic        m_cy     = 1'b0;

    function automatic obs_t model_out(int unsigned step, logic [3:0] op, logic cf,
                                       bit halted, logic rst);
        obs_t e;
        e    = '0;
        e.cf = cf;
        e.ts = 6'(1 << (step - 1));
        if (rst) begin
            e.cf = 1'b0;
            e.ts = 6'b000001;
            return e;
        end
        if (halted || (step == 4 && op == 4'hF)) begin
            e.halt = 1'b1;
            return e;
        end
        if (step == 1) begin
            e.pc_out = 1; e.mar_load = 1;
        end else if (step == 2) begin
            e.pc_inc = 1;
        end else if (step == 3) begin
            e.ram_out = 1; e.ir_load = 1;
        end else if (step == 4) begin
            if (op <= 4'h2) begin
                e.ir_out = 1; e.mar_load = 1;
            end else if (op == 4'h3 || (op == 4'h7 && JC_ON && cf)) begin
                e.ir_out = 1; e.pc_load = 1;
            end else if (op == 4'hE) begin
                e.a_out = 1; e.o_load = 1;
            end
        end else if (step == 5) begin
            if (op == 4'h0) begin
                e.ram_out = 1; e.a_load = 1;
            end else if (op == 4'h1 || op == 4'h2) begin
                e.ram_out = 1; e.b_load = 1;
            end
        end else begin
            if (op == 4'h1 || op == 4'h2) begin
                e.alu_out = 1; e.a_load = 1; e.alu_cut = (op == 4'h2);
            end
        end
        return e;
    endfunction

    // Effect of a rising edge on the model, using inputs of the closing cycle.
    task automatic model_edge();
        if (!m_rst && !m_halted) begin
            if (m_step == 4 && m_op == 4'hF) begin
                m_halted = 1;
            end else begin
                if (m_step == 6 && (m_op == 4'h1 || m_op == 4'h2)) m_cf = m_cy;
                m_step = (m_step == 6) ? 1 : m_step + 1;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic [3:0] op, input logic cy);
        @(posedge cu_clk);
        model_edge();
        #1;
        cu_rst = rst; cu_op = op; cu_cy = cy;
        m_rst  = rst; m_op  = op; m_cy  = cy;
        if (rst) begin
            m_step = 1; m_halted = 0; m_cf = 1'b0;
        end
        exp_q.push_back(model_out(m_step, m_op, m_cf, m_halted, m_rst));
    endtask

    task automatic instr(input logic [3:0] op, input logic cy);
        for (int i = 0; i < 6; i++) cycle(1'b0, op, cy);
    endtask

    // Monitor
    initial begin
        obs_t got, e;
        forever begin
            @(negedge cu_clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{cu_pc_out, cu_pc_inc, cu_pc_load, cu_mar_load, cu_ram_out,
                        cu_ir_load, cu_ir_out, cu_a_load, cu_a_out, cu_b_load,
                        cu_o_load, cu_alu_out, cu_alu_cut, cu_halt, cu_cf, cu_tstate};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL ctlword t=%0t got=%b want=%b", $time, got, e);
                n_checks++;
                if ($countones({cu_pc_out, cu_ram_out, cu_ir_out, cu_a_out, cu_alu_out}) <= 1)
                    n_pass++;
                else
                    $display("FAIL busexcl t=%0t drivers=%b want<=1 active", $time,
                             {cu_pc_out, cu_ram_out, cu_ir_out, cu_a_out, cu_alu_out});
            end
        end
    end

    // Driver
    initial begin
        logic [3:0] rop;
        int         halt_cnt;
        cu_rst = 1'b1; cu_op = 4'h0; cu_cy = 1'b0;

        cycle(1'b1, 4'h0, 1'b0);
        cycle(1'b1, 4'h0, 1'b0);

        instr(4'h1, 1'b1);                 // ADD, carry in -> cf=1
        instr(4'h2, 1'b0);                 // SUB, no carry -> cf=0
        instr(4'h1, 1'b1);                 // cf=1
        instr(4'h7, 1'b0);                 // JC with cf=1
        instr(4'h2, 1'b0);                 // cf=0
        instr(4'h7, 1'b1);                 // JC with cf=0
        instr(4'h0, 1'(($urandom) & 1));   // LDA
        instr(4'h3, 1'(($urandom) & 1));   // JMP
        instr(4'hE, 1'(($urandom) & 1));   // OUT
        instr(4'h5, 1'(($urandom) & 1));   // NOP
        instr(4'h1, 1'b1);                 // cf=1 before interrupted ADD

        // ADD interrupted by reset during T5
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h1, 1'b0);
        cycle(1'b1, 4'h1, 1'b1);
        instr(4'h1, 1'b0);

        // HLT: freeze at T4 for 20+ clocks even as cu_op wanders
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'hF, 1'b1);
        for (int i = 0; i < 22; i++) cycle(1'b0, 4'($urandom_range(0, 15)), 1'b1);
        cycle(1'b1, 4'h0, 1'b0);

        // Random traffic
        rop = 4'($urandom_range(0, 15));
        halt_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            logic r;
            halt_cnt = m_halted ? halt_cnt + 1 : 0;
            r = (halt_cnt >= 8) || ($urandom_range(0, 149) == 0);
            if (m_step == 6 || m_rst || m_halted) rop = 4'($urandom_range(0, 15));
            cycle(r, rop, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge cu_clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have cu_clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have cu_rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have cu_op, input, 4, opcode from instruction register upper nibble; valid during T4-T6.
REQ-004 SHALL have cu_cy, input, 1, carry from the ALU stage (bit 8 of the 9-bit sum/difference).
REQ-005 SHALL have the following 1-bit control outputs to the datapath: cu_pc_out, cu_pc_inc, cu_pc_load, cu_mar_load, cu_ram_out, cu_ir_load, cu_ir_out, cu_a_load, cu_a_out, cu_b_load, cu_o_load.
REQ-006 SHALL have cu_alu_out, output, 1, drives the ALU's bus-enable; cu_alu_cut, output, 1, selects subtract (1) or add (0).
REQ-007 SHALL have cu_halt, output, 1, processor halted; cu_cf, output, 1, registered carry flag.
REQ-008 SHALL have cu_tstate, output, 6, one-hot T-state (bit0=T1 ... bit5=T6).

Function
REQ-009 SHALL hold a 6-state one-hot ring counter T1->T2->...->T6->T1, advancing one state per clock when not halted.
REQ-010 SHALL decode every control output combinationally from current T-state and cu_op; unlisted outputs are 0 in every state.
REQ-011 SHALL drive, for all opcodes: T1 cu_pc_out+cu_mar_load; T2 cu_pc_inc; T3 cu_ram_out+cu_ir_load.
REQ-012 SHALL execute LDA (0000): T4 cu_ir_out+cu_mar_load; T5 cu_ram_out+cu_a_load; T6 none.
REQ-013 SHALL execute ADD (0001): T4 cu_ir_out+cu_mar_load; T5 cu_ram_out+cu_b_load; T6 cu_alu_out+cu_a_load, cu_alu_cut=0.
REQ-014 SHALL execute SUB (0010): as ADD but cu_alu_cut=1 in T6 only.
REQ-015 SHALL execute JMP (0011): T4 cu_ir_out+cu_pc_load; T5-T6 none.
REQ-016 SHALL execute OUT (1110): T4 cu_a_out+cu_o_load; T5-T6 none.
REQ-017 SHALL execute HLT (1111): on entering T4, assert cu_halt, freeze counter at T4, drive all other control outputs 0, until reset.
REQ-018 SHALL treat every other opcode as NOP (T4-T6 none), except 0111 per REQ-024.
REQ-019 SHALL load cu_cf from cu_cy at the rising edge ending T6 of ADD or SUB only; otherwise hold.
REQ-020 SHALL keep cu_alu_cut=0 whenever cu_alu_out=0.
REQ-021 SHALL never assert two bus drivers (cu_pc_out, cu_ram_out, cu_ir_out, cu_a_out, cu_alu_out) in the same state.

Reset
REQ-022 SHALL, while cu_rst=1 (asynchronously, including mid-instruction or while halted): T-state=T1, cu_halt=0, cu_cf=0, and all control outputs forced 0; reset wins over halt.
REQ-023 SHALL begin fetch (T1 decode) in the first cycle after cu_rst deasserts.

Configuration
REQ-024 SHALL, with CU_JC_EN defined, implement JC (0111): T4 cu_ir_out+cu_pc_load if cu_cf=1, else none; T5-T6 none.
REQ-025 SHALL, without CU_JC_EN, decode 0111 as NOP; cu_cf register and ADD/SUB capture remain present.

Verification
REQ-026 Reset pulse mid-T5 of ADD -> cu_tstate=000001, all controls 0, cu_cf=0 during reset; T1 decode next cycle.
REQ-027 cu_op=0001, cu_cy=1 through T6 -> T6 cu_alu_out=1, cu_a_load=1, cu_alu_cut=0; cu_cf=1 after edge.
REQ-028 cu_op=0010, cu_cy=0 -> T6 cu_alu_cut=1; cu_cf=0; T4/T5 cu_alu_cut=0.
REQ-029 cu_op=1111 -> cu_halt=1 from T4, cu_tstate stays 001000 for 20 clocks; reset clears it.
REQ-030 CU_JC_EN defined, cu_cf=1, cu_op=0111 -> T4 cu_pc_load=1; repeat with cu_cf=0 -> cu_pc_load=0; undefined -> cu_pc_load=0 in both.
REQ-031 Random opcodes over 1000 cycles -> bus-driver mutual exclusion (REQ-021) never violated.
